lsu: RTL

Load/store unit sitting directly upstream of the DPI-backed data memory. It accepts one memory request at a time from the execute stage over a valid/ready handshake and converts byte/half/word accesses into word-aligned memory transactions with byte write masks. It extracts and sign- or zero-extends load data, and hands the result to write-back over a second valid/ready handshake. A configurable access delay models multi-cycle memory so the core tolerates non-single-cycle data memory.

---
 rtl/lsu.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one request at a time, byte-lane store masks, load extension
// Converts byte/half/word accesses into word-aligned transactions with a configurable access delay.
module lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DELAY  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic                  in_wen,
  input  logic                  in_ren,
  input  logic [1:0]            in_size,
  input  logic                  in_unsigned,
  input  logic [4:0]            in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic [4:0]            out_rd,
  output logic                  out_misalign,
  output logic                  mem_valid,
  output logic [DATA_WIDTH-1:0] mem_raddr,
  output logic [DATA_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic [7:0]            mem_wmask,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(MEM_DELAY) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    wen_q, wen_d;
  logic                    ren_q, ren_d;
  logic                    uns_q, uns_d;
  logic                    mis_q, mis_d;
  logic [1:0]              size_q, size_d;
  logic [4:0]              rd_q, rd_d;
  logic [7:0]              mask_q, mask_d;

  logic                    in_mis;
  logic [7:0]              in_mask;
  logic [DATA_WIDTH-1:0]   lane_word;
  logic [DATA_WIDTH-1:0]   load_ext;

  // Sizes 2 and 3 are both word accesses, so size[1] selects word alignment.
  assign in_mis = (in_ren | in_wen) &&
                  (((in_size == 2'd1) && in_addr[0]) || (in_size[1] && (in_addr[1:0] != 2'b00)));

  always_comb begin
    in_mask = 8'h0F;
    case (in_size)
      2'd0:    in_mask = 8'h01;
      2'd1:    in_mask = 8'h03;
      default: in_mask = 8'h0F;
    endcase
    in_mask = in_mask << in_addr[1:0];
  end

  assign lane_word = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = lane_word;
    case (size_q)
      2'd0:    load_ext = {{(DATA_WIDTH-8){lane_word[7] & ~uns_q}}, lane_word[7:0]};
      2'd1:    load_ext = {{(DATA_WIDTH-16){lane_word[15] & ~uns_q}}, lane_word[15:0]};
      default: load_ext = lane_word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wen_d   = wen_q;
    ren_d   = ren_q;
    uns_d   = uns_q;
    mis_d   = mis_q;
    size_d  = size_q;
    rd_d    = rd_q;
    mask_d  = mask_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          addr_d  = in_addr;
          wdata_d = in_wdata;
          wen_d   = in_wen;
          ren_d   = in_ren;
          uns_d   = in_unsigned;
          size_d  = in_size;
          rd_d    = in_rd;
          mis_d   = in_mis;
          rdata_d = '0;
          mask_d  = (in_wen && !in_mis) ? in_mask : 8'h00;
          if (in_mis || !(in_ren || in_wen)) begin
            state_d = S_RESP;
          end else begin
            state_d = S_ACCESS;
            cnt_d   = CW'(MEM_DELAY - 1);
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          // A combined store+load is treated as a store only.
          if (ren_q && !wen_q) rdata_d = load_ext;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= 2'd0;
      rd_q    <= 5'd0;
      mask_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      uns_q   <= uns_d;
      mis_q   <= mis_d;
      size_q  <= size_d;
      rd_q    <= rd_d;
      mask_q  <= mask_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE) && !rst;
  assign out_valid    = (state_q == S_RESP);
  assign out_rdata    = rdata_q;
  assign out_rd       = rd_q;
  assign out_misalign = mis_q;
  assign mem_valid    = (state_q == S_ACCESS);
  // The counter sits at its load value only during the first access cycle: one write per store.
  assign mem_wen      = (state_q == S_ACCESS) && wen_q && (cnt_q == CW'(MEM_DELAY - 1));
  assign mem_raddr    = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign mem_waddr    = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign mem_wdata    = wdata_q << {addr_q[1:0], 3'b000};
  assign mem_wmask    = mask_q;

endmodule
